// File: rtl/spm_pkg.sv
// Shared types for the serial-parallel multiplier job sequencer: FSM states,
// default widths and the default-width job record.
package spm_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_TAG_W = 4;

   // Job lifecycle: pick up a job, clear the multiplier, start it, wait, present result.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      START = 3'd2,
      RUN   = 3'd3,
      HOLD  = 3'd4
   } state_e;

   // One buffered operand pair with its tag, laid out as it sits in the FIFO.
   typedef struct packed {
      logic [DEF_WIDTH-1:0] mp;
      logic [DEF_WIDTH-1:0] mc;
      logic [DEF_TAG_W-1:0] tag;
   } job_t;

endpackage

// File: rtl/spm_job_fifo.sv
// Synchronous FIFO holding pending operand pairs. Pointers carry one extra
// wrap bit so full and empty can be told apart without a counter.
module spm_job_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 68
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          pop_i,
   output logic [DW-1:0] rdata_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q;
   logic [AW:0]   rd_ptr_q;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance; a push into a full FIFO is dropped even if a pop happens the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage write; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/spm_job_sequencer.sv
// Control stage in front of the serial-parallel multiplier: buffers operand
// pairs, runs one job at a time (clear, start, wait for done or watchdog) and
// presents the product with its tag on a valid/ready result port.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and an offered result stays stable until
// it is taken.
module spm_job_sequencer
   import spm_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = DEF_TAG_W,
   parameter int TIMEOUT    = 80
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_mp,
   input  logic [WIDTH-1:0]   in_mc,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               mul_rst,
   output logic               mul_start,
   output logic [WIDTH-1:0]   mul_mp,
   output logic [WIDTH-1:0]   mul_mc,
   input  logic [2*WIDTH-1:0] mul_p,
   input  logic               mul_done,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_timeout,
   output logic               busy,
   output logic [2:0]         dbg_state_o
);

   localparam int JW = 2*WIDTH + TAG_W;
   localparam int CW = $clog2(TIMEOUT);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   mp_q, mp_d, mc_q, mc_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] p_q, p_d;
   logic               to_q, to_d;

   logic               fifo_full, fifo_empty, fifo_pop, fifo_push;
   logic [JW-1:0]      fifo_rdata;

   assign in_ready  = !rst && !fifo_full;
   assign fifo_push = in_valid && in_ready;

   spm_job_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (JW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .wdata_i ({in_mp, in_mc, in_tag}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Next-state logic: job pickup, watchdog counting and result capture.
   always_comb begin
      state_d  = state_q;
      mp_d     = mp_q;
      mc_d     = mc_q;
      tag_d    = tag_q;
      cnt_d    = cnt_q;
      p_d      = p_q;
      to_d     = to_q;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop             = 1'b1;
               {mp_d, mc_d, tag_d}  = fifo_rdata;
               state_d              = CLEAR;
            end
         end
         CLEAR: state_d = START;
         START: begin
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            // A real done wins over the watchdog firing on the same cycle.
            if (mul_done) begin
               p_d     = mul_p;
               to_d    = 1'b0;
               state_d = HOLD;
            end else if (cnt_q == CW'(TIMEOUT-1)) begin
               p_d     = '0;
               to_d    = 1'b1;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, job and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mp_q    <= '0;
         mc_q    <= '0;
         tag_q   <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mp_q    <= mp_d;
         mc_q    <= mc_d;
         tag_q   <= tag_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         to_q    <= to_d;
      end
   end

   assign mul_rst     = rst || (state_q == CLEAR);
   assign mul_start   = !rst && (state_q == START);
   assign mul_mp      = mp_q;
   assign mul_mc      = mc_q;
   assign out_valid   = !rst && (state_q == HOLD);
   assign out_p       = p_q;
   assign out_tag     = tag_q;
   assign out_timeout = to_q;
   assign busy        = !rst && ((state_q != IDLE) || !fifo_empty);
   assign dbg_state_o = state_q;

endmodule
